pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 179 +++++++++++++++++
 tb/tb_pwm_capture.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with an 8-bit duty ratio.
// Two-flop input sync, edge-to-edge counters, 9-step restoring divide.
module pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic             clk_16mhz,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [7:0]       duty,
  output logic             valid,
  output logic             stuck,
  output logic             overrun
);

  typedef enum logic {IDLE, MEAS} state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_q, state_d;

  logic s1_q, s_q, sd_q;
  logic rise;

  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;

  logic             busy_q, busy_d;
  logic [3:0]       it_q, it_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] lat_hi_q, lat_hi_d;
  logic [8:0]       num_q, num_d;
  logic [7:0]       quo_q, quo_d;

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [7:0]       duty_q, duty_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             ovr_q, ovr_d;

  logic [CNT_W-1:0] sh;
  logic             ge;

  assign rise = s_q & ~sd_q;

  // Remainder stays below the divisor, so its top bit
  // shifted out means the shifted value already exceeds it.
  assign sh = {rem_q[CNT_W-2:0], num_q[8]};
  assign ge = rem_q[CNT_W-1] | (sh >= div_q);

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    busy_d   = busy_q;
    it_d     = it_q;
    rem_d    = rem_q;
    div_d    = div_q;
    lat_hi_d = lat_hi_q;
    num_d    = num_q;
    quo_d    = quo_q;
    period_d = period_q;
    high_d   = high_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    ovr_d    = ovr_q;

    if (busy_q) begin
      rem_d = ge ? (sh - div_q) : sh;
      num_d = {num_q[7:0], 1'b0};
      quo_d = {quo_q[6:0], ge};
      it_d  = it_q + 4'd1;
      if (it_q == 4'd8) begin
        busy_d   = 1'b0;
        valid_d  = 1'b1;
        period_d = div_q;
        high_d   = lat_hi_q;
        duty_d   = quo_q[7] ? 8'hff : {quo_q[6:0], ge};
        stuck_d  = 1'b0;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEAS;
          per_d   = ONE;
          hi_d    = ONE;
        end
      end
      MEAS: begin
        if (rise) begin
          if (busy_q) begin
            ovr_d = 1'b1;
          end else begin
            busy_d   = 1'b1;
            it_d     = 4'd0;
            rem_d    = hi_q >> 1;
            num_d    = {hi_q[0], 8'h00};
            quo_d    = 8'h00;
            div_d    = per_q;
            lat_hi_d = hi_q;
          end
          per_d = ONE;
          hi_d  = ONE;
        end else if (per_q == CNT_MAX) begin
          state_d  = IDLE;
          per_d    = '0;
          hi_d     = '0;
          valid_d  = 1'b1;
          period_d = '0;
          high_d   = '0;
          duty_d   = s_q ? 8'hff : 8'h00;
          stuck_d  = 1'b1;
        end else begin
          per_d = per_q + ONE;
          hi_d  = hi_q + {{(CNT_W-1){1'b0}}, s_q};
        end
      end
    endcase
  end

  always_ff @(posedge clk_16mhz) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s_q      <= 1'b0;
      sd_q     <= 1'b0;
      state_q  <= IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      busy_q   <= 1'b0;
      it_q     <= 4'd0;
      rem_q    <= '0;
      div_q    <= '0;
      lat_hi_q <= '0;
      num_q    <= 9'd0;
      quo_q    <= 8'd0;
      period_q <= '0;
      high_q   <= '0;
      duty_q   <= 8'd0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      s1_q     <= pwm_in;
      s_q      <= s1_q;
      sd_q     <= s_q;
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      busy_q   <= busy_d;
      it_q     <= it_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      lat_hi_q <= lat_hi_d;
      num_q    <= num_d;
      quo_q    <= quo_d;
      period_q <= period_d;
      high_q   <= high_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      ovr_q    <= ovr_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign duty      = duty_q;
  assign valid     = valid_q;
  assign stuck     = stuck_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: waveform tables and random PWM against
// an edge-event reference model of the capture rules.
module tb_pwm_capture;

  localparam int W    = 8;
  localparam int MAXC = 255;

  logic         clk_16mhz = 1'b0;
  logic         rst = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] period, high_time;
  logic [7:0]   duty;
  logic         valid, stuck, overrun;

  int total = 0;
  int bad   = 0;

  int w[$];
  int ra = -1;
  int rb = -1;
  int nc = 0;

  logic       xv[], xs[], xo[], yv[], ys[], yo[];
  logic [7:0] xp[], xh[], xd[], yp[], yh[], yd[];

  pwm_capture #(.CNT_W(W)) dut (
    .clk_16mhz(clk_16mhz),
    .rst(rst),
    .pwm_in(pwm_in),
    .period(period),
    .high_time(high_time),
    .duty(duty),
    .valid(valid),
    .stuck(stuck),
    .overrun(overrun)
  );

  always #31 clk_16mhz = ~clk_16mhz;

  // synchronised level seen by the capture logic in cycle k
  function automatic int sv(input int k);
    if (ra >= 0 && k >= ra + 1 && k <= rb + 2) return 0;
    if (k < 2 || k - 2 >= w.size()) return 0;
    return w[k-2];
  endfunction

  task automatic add_pwm(input int p, input int h, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < p; i++)
        w.push_back(i < h ? 1 : 0);
  endtask

  task automatic model();
    bit ev[], eo[], es[];
    int ep[], eh[], ed[];
    bit idle, r, inrst;
    int last, acc, s, p, h, q;
    int cp, ch, cd;
    bit cs, co;
    ev = new[nc]; eo = new[nc]; es = new[nc];
    ep = new[nc]; eh = new[nc]; ed = new[nc];
    idle = 1; last = 0; acc = -100;
    for (int k = 1; k < nc; k++) begin
      if (ra >= 0 && k >= ra && k <= rb) begin
        if (k == ra)
          for (int j = ra + 1; j < nc; j++) begin
            ev[j] = 0;
            eo[j] = 0;
          end
        idle = 1;
        acc = -100;
        continue;
      end
      s = sv(k);
      r = (s == 1 && sv(k-1) == 0);
      if (idle) begin
        if (r) begin
          idle = 0;
          last = k;
        end
      end else if (r) begin
        p = k - last;
        h = 0;
        for (int j = last; j < k; j++) h += sv(j);
        if (k <= acc + 9) begin
          if (k + 1 < nc) eo[k+1] = 1;
        end else begin
          acc = k;
          q = h * 256 / p;
          if (k + 10 < nc) begin
            ev[k+10] = 1; ep[k+10] = p; eh[k+10] = h;
            ed[k+10] = q > 255 ? 255 : q; es[k+10] = 0;
          end
        end
        last = k;
      end else if (k - last == MAXC) begin
        idle = 1;
        if (k + 1 < nc) begin
          ev[k+1] = 1; ep[k+1] = 0; eh[k+1] = 0;
          ed[k+1] = s ? 255 : 0; es[k+1] = 1;
        end
      end
    end
    xv = new[nc]; xs = new[nc]; xo = new[nc];
    xp = new[nc]; xh = new[nc]; xd = new[nc];
    cp = 0; ch = 0; cd = 0; cs = 0; co = 0;
    for (int k = 0; k < nc; k++) begin
      inrst = (ra >= 0 && k >= ra + 1 && k <= rb + 1);
      if (inrst) begin
        cp = 0; ch = 0; cd = 0; cs = 0; co = 0;
      end else begin
        if (ev[k]) begin
          cp = ep[k]; ch = eh[k]; cd = ed[k]; cs = es[k];
        end
        if (eo[k]) co = 1;
      end
      xv[k] = ev[k] && !inrst;
      xp[k] = cp[7:0]; xh[k] = ch[7:0]; xd[k] = cd[7:0];
      xs[k] = cs; xo[k] = co;
    end
  endtask

  task automatic run(input int n);
    nc = n;
    yv = new[n]; ys = new[n]; yo = new[n];
    yp = new[n]; yh = new[n]; yd = new[n];
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk_16mhz);
    #1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk_16mhz);
        #1;
      end
      yv[k] = valid; ys[k] = stuck; yo[k] = overrun;
      yp[k] = period; yh[k] = high_time; yd[k] = duty;
      rst = (ra >= 0 && k >= ra && k <= rb);
      pwm_in = (k < w.size()) ? w[k][0] : 1'b0;
    end
    model();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pwm_in = 1'($urandom_range(0, 1));
      @(posedge clk_16mhz);
      #1;
      total++;
      if ({period, high_time, duty, valid, stuck, overrun} !== '0) begin
        bad++;
        $display("FAIL reset_outs got p=%0d h=%0d d=%0d v=%0b s=%0b o=%0b want all 0",
                 period, high_time, duty, valid, stuck, overrun);
      end
    end
  endtask

  task automatic test_steady();
    int nv;
    for (int pass = 0; pass < 2; pass++) begin
      w.delete(); ra = -1; rb = -1;
      add_pwm(100, pass == 0 ? 25 : 99, 3);
      run(w.size() + 20);
      nv = 0;
      for (int k = 0; k < nc; k++) begin
        if (yv[k] === 1'b1) nv++;
        total++;
        if (yv[k] !== xv[k]) begin
          bad++;
          $display("FAIL steady valid@%0d got=%0b want=%0b", k, yv[k], xv[k]);
        end
        total++;
        if ({yp[k], yh[k], yd[k], ys[k], yo[k]} !== {xp[k], xh[k], xd[k], xs[k], xo[k]}) begin
          bad++;
          $display("FAIL steady outs@%0d got p=%0d h=%0d d=%0d s=%0b o=%0b want p=%0d h=%0d d=%0d s=%0b o=%0b",
                   k, yp[k], yh[k], yd[k], ys[k], yo[k], xp[k], xh[k], xd[k], xs[k], xo[k]);
        end
      end
      total++;
      if (nv != 2) begin
        bad++;
        $display("FAIL steady pulses got=%0d want=2", nv);
      end
      total++;
      if (yv[112] !== 1'b1 || yp[112] !== 8'd100 || yd[112] !== (pass == 0 ? 8'd64 : 8'd253)) begin
        bad++;
        $display("FAIL steady first@112 got v=%0b p=%0d d=%0d want v=1 p=100 d=%0d",
                 yv[112], yp[112], yd[112], pass == 0 ? 64 : 253);
      end
    end
  endtask

  task automatic test_timeout();
    int nv;
    for (int pass = 0; pass < 2; pass++) begin
      w.delete(); ra = -1; rb = -1;
      if (pass == 0) repeat (300) w.push_back(1);
      else w.push_back(1);
      run(320);
      nv = 0;
      for (int k = 0; k < nc; k++) begin
        if (yv[k] === 1'b1) nv++;
        total++;
        if (yv[k] !== xv[k]) begin
          bad++;
          $display("FAIL timeout valid@%0d got=%0b want=%0b", k, yv[k], xv[k]);
        end
        total++;
        if ({yp[k], yh[k], yd[k], ys[k], yo[k]} !== {xp[k], xh[k], xd[k], xs[k], xo[k]}) begin
          bad++;
          $display("FAIL timeout outs@%0d got p=%0d h=%0d d=%0d s=%0b o=%0b want p=%0d h=%0d d=%0d s=%0b o=%0b",
                   k, yp[k], yh[k], yd[k], ys[k], yo[k], xp[k], xh[k], xd[k], xs[k], xo[k]);
        end
      end
      total++;
      if (nv != 1 || yv[258] !== 1'b1 || yp[258] !== 8'd0 || yh[258] !== 8'd0 ||
          ys[258] !== 1'b1 || yd[258] !== (pass == 0 ? 8'd255 : 8'd0)) begin
        bad++;
        $display("FAIL timeout result pulses=%0d v=%0b p=%0d h=%0d d=%0d s=%0b want 1 1 0 0 %0d 1",
                 nv, yv[258], yp[258], yh[258], yd[258], ys[258], pass == 0 ? 255 : 0);
      end
    end
  endtask

  task automatic test_overrun();
    w.delete(); ra = -1; rb = -1;
    add_pwm(8, 4, 6);
    run(w.size() + 20);
    for (int k = 0; k < nc; k++) begin
      total++;
      if (yv[k] !== xv[k]) begin
        bad++;
        $display("FAIL overrun valid@%0d got=%0b want=%0b", k, yv[k], xv[k]);
      end
      total++;
      if ({yp[k], yh[k], yd[k], ys[k], yo[k]} !== {xp[k], xh[k], xd[k], xs[k], xo[k]}) begin
        bad++;
        $display("FAIL overrun outs@%0d got p=%0d h=%0d d=%0d s=%0b o=%0b want p=%0d h=%0d d=%0d s=%0b o=%0b",
                 k, yp[k], yh[k], yd[k], ys[k], yo[k], xp[k], xh[k], xd[k], xs[k], xo[k]);
      end
    end
    total++;
    if (yv[20] !== 1'b1 || yp[20] !== 8'd8 || yh[20] !== 8'd4 || yd[20] !== 8'd128 ||
        yv[28] !== 1'b0 || yv[36] !== 1'b1 || yo[nc-1] !== 1'b1) begin
      bad++;
      $display("FAIL overrun pattern got v20=%0b p=%0d h=%0d d=%0d v28=%0b v36=%0b o=%0b want 1 8 4 128 0 1 1",
               yv[20], yp[20], yh[20], yd[20], yv[28], yv[36], yo[nc-1]);
    end
  endtask

  task automatic test_reset_abort();
    int fv;
    w.delete(); ra = 27; rb = 29;
    add_pwm(20, 5, 6);
    run(w.size() + 10);
    fv = -1;
    for (int k = 0; k < nc; k++) begin
      if (yv[k] === 1'b1 && fv < 0) fv = k;
      total++;
      if (yv[k] !== xv[k]) begin
        bad++;
        $display("FAIL abort valid@%0d got=%0b want=%0b", k, yv[k], xv[k]);
      end
      total++;
      if ({yp[k], yh[k], yd[k], ys[k], yo[k]} !== {xp[k], xh[k], xd[k], xs[k], xo[k]}) begin
        bad++;
        $display("FAIL abort outs@%0d got p=%0d h=%0d d=%0d s=%0b o=%0b want p=%0d h=%0d d=%0d s=%0b o=%0b",
                 k, yp[k], yh[k], yd[k], ys[k], yo[k], xp[k], xh[k], xd[k], xs[k], xo[k]);
      end
    end
    total++;
    if (fv != 72) begin
      bad++;
      $display("FAIL abort first_valid got=%0d want=72", fv);
    end
    total++;
    if ({yp[30], yh[30], yd[30], yv[32], ys[30], yo[30]} !== '0) begin
      bad++;
      $display("FAIL abort cleared got p=%0d h=%0d d=%0d v32=%0b s=%0b o=%0b want all 0",
               yp[30], yh[30], yd[30], yv[32], ys[30], yo[30]);
    end
  endtask

  task automatic test_random();
    int p, v, nv;
    w.delete(); ra = -1; rb = -1;
    repeat (40) begin
      if ($urandom_range(0, 9) == 0) begin
        v = $urandom_range(0, 1);
        repeat ($urandom_range(256, 300)) w.push_back(v);
      end else begin
        p = $urandom_range(2, 40);
        add_pwm(p, $urandom_range(1, p - 1), $urandom_range(1, 4));
      end
    end
    run(w.size() + 20);
    nv = 0;
    for (int k = 0; k < nc; k++) begin
      if (xv[k]) nv++;
      total++;
      if (yv[k] !== xv[k]) begin
        bad++;
        $display("FAIL random valid@%0d got=%0b want=%0b", k, yv[k], xv[k]);
      end
      total++;
      if ({yp[k], yh[k], yd[k], ys[k], yo[k]} !== {xp[k], xh[k], xd[k], xs[k], xo[k]}) begin
        bad++;
        $display("FAIL random outs@%0d got p=%0d h=%0d d=%0d s=%0b o=%0b want p=%0d h=%0d d=%0d s=%0b o=%0b",
                 k, yp[k], yh[k], yd[k], ys[k], yo[k], xp[k], xh[k], xd[k], xs[k], xo[k]);
      end
    end
    $display("random run: %0d cycles, %0d expected results", nc, nv);
  endtask

  initial begin
    test_reset();
    test_steady();
    test_timeout();
    test_overrun();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
